// File: rtl/div_seq_param.sv
// Sequential restoring divider, one quotient bit per clock, unsigned or signed per operation.
// Signed operands are divided as magnitudes and the signs are applied in FIX.
//
// state  | meaning
// S_IDLE | waiting for start, operands latched on acceptance
// S_CALC | one restoring iteration per cycle, WIDTH cycles
// S_FIX  | sign fix-up, flag resolution, result write, done pulse
module div_seq_param #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_i_q, dbz_i_d;
  logic             ovf_i_q, ovf_i_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   p_sub;
  logic             qbit;
  logic [WIDTH-1:0] rem_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dbz_i_d = dbz_i_q;
    ovf_i_d = ovf_i_q;
    done_d  = 1'b0;
    y_d     = y_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    p_sh    = {p_q[WIDTH-1:0], dq_q[WIDTH-1]};
    p_sub   = p_sh - {1'b0, dvs_q};
    qbit    = (p_sh >= {1'b0, dvs_q});
    rem_mag = p_q[WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          dq_d    = (sgn && a[WIDTH-1]) ? -a : a;
          dvs_d   = (sgn && b[WIDTH-1]) ? -b : b;
          q_neg_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg_d = sgn && a[WIDTH-1];
          dbz_i_d = (b == '0);
          ovf_i_d = sgn && (a == MIN) && (b == '1);
          p_d     = '0;
          cnt_d   = CNTW'(WIDTH);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // The dividend register doubles as the quotient register.
        p_d   = qbit ? p_sub : p_sh;
        dq_d  = {dq_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dbz_i_q) begin
          y_d   = '1;
          rem_d = a_q;
          dbz_d = 1'b1;
          ovf_d = 1'b0;
        end else if (ovf_i_q) begin
          y_d   = MIN;
          rem_d = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b1;
        end else begin
          y_d   = q_neg_q ? -dq_q : dq_q;
          rem_d = r_neg_q ? -rem_mag : rem_mag;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_i_q <= 1'b0;
      ovf_i_q <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_i_q <= dbz_i_d;
      ovf_i_q <= ovf_i_d;
      done_q  <= done_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign y         = y_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Self-checking bench for div_seq_param (WIDTH=16): scoreboard of expected results
// built from a behavioural division model, checked when done pulses.
module tb_div_seq_param;

  localparam int W   = 16;
  localparam int LAT = 17;

  typedef struct packed {
    logic [W-1:0] y;
    logic [W-1:0] rem;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dbz, ovf;
  logic [W-1:0] y, remainder;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  div_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .remainder(remainder), .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic signed [W-1:0] sa, sb;
    sa = av;
    sb = bv;
    e = '0;
    if (bv == 0) begin
      e.y = '1; e.rem = av; e.dbz = 1'b1;
    end else if (s && av == 16'h8000 && bv == 16'hFFFF) begin
      e.y = 16'h8000; e.rem = '0; e.ovf = 1'b1;
    end else if (s) begin
      e.y = sa / sb; e.rem = sa % sb;
    end else begin
      e.y = av / bv; e.rem = av % bv;
    end
    return e;
  endfunction

  // Returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1; sgn = s; a = av; b = bv;
    exp_q.push_back(model(s, av, bv));
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sgn = $urandom;
  endtask

  // Counts falling edges until done; cyc_in lets a caller account for cycles already spent.
  task automatic wait_done(input int cyc_in, output int cyc, output int busy_cyc, output bit timeout);
    cyc = cyc_in; busy_cyc = cyc_in; timeout = 1'b0;
    while (!done && cyc < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    if (!done) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, y, remainder, dbz, ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b y=%h rem=%h dbz=%b ovf=%b, want all 0",
               busy, done, y, remainder, dbz, ovf);
    end
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [W-1:0] va[3] = '{16'd100, 16'hFFFF, 16'hFFFF};
    logic [W-1:0] vb[3] = '{16'd7, 16'h8001, 16'h0001};
    int cyc, bcyc; bit to; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, va[i], vb[i]);
      wait_done(0, cyc, bcyc, to);
      e = exp_q.pop_front();
      n_vec++;
      if (to || {y, remainder, dbz, ovf} !== e) begin
        n_err++;
        $display("FAIL unsigned_%0d: got y=%h rem=%h dbz=%b ovf=%b timeout=%b, want y=%h rem=%h dbz=%b ovf=%b",
                 i, y, remainder, dbz, ovf, to, e.y, e.rem, e.dbz, e.ovf);
      end
      if (i == 0) begin
        n_vec++;
        if (cyc != LAT || bcyc != LAT) begin
          n_err++;
          $display("FAIL unsigned_latency: got done_after=%0d busy_cycles=%0d, want %0d and %0d", cyc, bcyc, LAT, LAT);
        end
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || y !== e.y) begin
        n_err++;
        $display("FAIL done_pulse_hold_%0d: got done=%b y=%h, want done=0 y=%h", i, done, y, e.y);
      end
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] va[2] = '{16'hFFF9, 16'h0007};
    logic [W-1:0] vb[2] = '{16'h0002, 16'hFFFE};
    int cyc, bcyc; bit to; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, va[i], vb[i]);
      wait_done(0, cyc, bcyc, to);
      e = exp_q.pop_front();
      n_vec++;
      if (to || {y, remainder, dbz, ovf} !== e) begin
        n_err++;
        $display("FAIL signed_%0d: got y=%h rem=%h dbz=%b ovf=%b, want y=%h rem=%h dbz=%b ovf=%b",
                 i, y, remainder, dbz, ovf, e.y, e.rem, e.dbz, e.ovf);
      end
    end
  endtask

  task automatic test_flags();
    logic         vs[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] va[3] = '{16'h1234, 16'h1234, 16'h8000};
    logic [W-1:0] vb[3] = '{16'h0000, 16'h0000, 16'hFFFF};
    int cyc, bcyc; bit to; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(vs[i], va[i], vb[i]);
      wait_done(0, cyc, bcyc, to);
      e = exp_q.pop_front();
      n_vec++;
      if (to || cyc != LAT || {y, remainder, dbz, ovf} !== e) begin
        n_err++;
        $display("FAIL flags_%0d: got y=%h rem=%h dbz=%b ovf=%b lat=%0d, want y=%h rem=%h dbz=%b ovf=%b lat=%0d",
                 i, y, remainder, dbz, ovf, cyc, e.y, e.rem, e.dbz, e.ovf, LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bcyc; bit to; exp_t e; bit extra;
    issue(1'b0, 16'd100, 16'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; a = 16'd1; b = 16'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, cyc, bcyc, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || cyc != LAT || {y, remainder, dbz, ovf} !== e) begin
      n_err++;
      $display("FAIL ignore_start: got y=%h rem=%h lat=%0d, want y=%h rem=%h lat=%0d",
               y, remainder, cyc, e.y, e.rem, LAT);
    end
    extra = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    n_vec++;
    if (extra) begin
      n_err++;
      $display("FAIL ignore_start_no_second_op: got busy/done activity=%b, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc; bit to; exp_t e;
    issue(1'b0, 16'd1000, 16'd33);
    wait_done(0, cyc, bcyc, to);
    start = 1'b1; sgn = 1'b1; a = 16'hFF00; b = 16'd7;
    exp_q.push_back(model(1'b1, 16'hFF00, 16'd7));
    e = exp_q.pop_front();
    n_vec++;
    if (to || {y, remainder, dbz, ovf} !== e) begin
      n_err++;
      $display("FAIL b2b_first: got y=%h rem=%h, want y=%h rem=%h", y, remainder, e.y, e.rem);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    wait_done(0, cyc, bcyc, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || cyc != LAT || {y, remainder, dbz, ovf} !== e) begin
      n_err++;
      $display("FAIL b2b_second: got y=%h rem=%h lat=%0d, want y=%h rem=%h lat=%0d",
               y, remainder, cyc, e.y, e.rem, LAT);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, bcyc; bit to; exp_t e; bit seen;
    issue(1'b0, 16'd999, 16'd3);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    #1;
    n_vec++;
    if ({busy, done, y, remainder, dbz, ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_abort: got busy=%b done=%b y=%h rem=%h, want all 0", busy, done, y, remainder);
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL reset_no_done: got done pulse=%b, want 0", seen);
    end
    rst = 1'b1;
    issue(1'b0, 16'd50, 16'd5);
    wait_done(0, cyc, bcyc, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || cyc != LAT || {y, remainder, dbz, ovf} !== e) begin
      n_err++;
      $display("FAIL after_reset: got y=%h rem=%h lat=%0d, want y=%h rem=%h lat=%0d",
               y, remainder, cyc, e.y, e.rem, LAT);
    end
  endtask

  task automatic test_random();
    int cyc, bcyc; bit to; exp_t e;
    logic s; logic [W-1:0] av, bv;
    for (int i = 0; i < 24; i++) begin
      s  = $urandom_range(0, 1);
      av = $urandom;
      bv = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      if (i == 0) begin s = 1'b1; av = 16'h8000; bv = 16'h0001; end
      if (i == 1) begin s = 1'b1; av = 16'h8000; bv = 16'h8000; end
      issue(s, av, bv);
      wait_done(0, cyc, bcyc, to);
      e = exp_q.pop_front();
      n_vec++;
      if (to || {y, remainder, dbz, ovf} !== e) begin
        n_err++;
        $display("FAIL random_%0d (sgn=%b %h/%h): got y=%h rem=%h dbz=%b ovf=%b, want y=%h rem=%h dbz=%b ovf=%b",
                 i, s, av, bv, y, remainder, dbz, ovf, e.y, e.rem, e.dbz, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_flags();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq_param.md
# div_seq_param

Parametrised sequential integer divider that computes one quotient bit per clock for WIDTH-bit operands. It supports an unsigned or signed (two's complement) mode selected per operation. It flags divide-by-zero and signed overflow. It is the general-purpose successor to the fixed 16-bit sequential divider and sits on the datapath of arithmetic units that can tolerate multi-cycle latency in exchange for small area.

## Interface
- WIDTH, 16: operand and result width in bits (≥ 2).
- CNTW, $clog2(WIDTH+1): iteration counter width (derived; do not override).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- start  in  1  request; accepted only when busy=0.
- sgn  in  1  mode sampled with start: 0 unsigned, 1 signed.
- a  in  WIDTH  dividend, sampled with start.
- b  in  WIDTH  divisor, sampled with start.
- busy  out  1  high from acceptance until the result is written.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- y  out  WIDTH  quotient.
- remainder  out  WIDTH  remainder.
- dbz  out  1  divide-by-zero flag for the last result.
- ovf  out  1  signed overflow flag for the last result (MIN / -1).

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - If start=1, latch sgn, the signs of a and b, |a| and |b| (magnitudes only when sgn=1; raw values otherwise).
  - Latch dbz_i=(b==0) and ovf_i=(sgn & a==MIN & b==all-ones).
  - Clear the partial remainder and set count=WIDTH, then go to CALC.
- CALC, restoring algorithm, one iteration per cycle:
  - Partial remainder P is WIDTH+1 bits wide, so no carry is lost for divisors ≥ 2^(WIDTH-1).
  - Each cycle: P={P[WIDTH-1:0], dividend MSB}; shift the dividend left.
  - If P ≥ {0,divisor}: P=P-divisor and qbit=1; else qbit=0. Shift qbit into the quotient register.
  - Decrement count. When count reaches 0 after an iteration, go to FIX.
- FIX writes the outputs, sets done=1, and returns to IDLE.
  - dbz_i: y=all-ones, remainder=a (original), dbz=1, ovf=0.
  - ovf_i: y=MIN (0b10…0), remainder=0, ovf=1, dbz=0.
  - Signed otherwise: y is negated if the signs of a and b differ (truncation toward zero). remainder is negated if a<0, so it takes the dividend's sign. dbz=ovf=0.
  - Unsigned otherwise: y=quotient, remainder=P[WIDTH-1:0], dbz=ovf=0.
- Latency is constant for every case, including dbz and ovf; there is no early exit.
- Magnitude |MIN| is representable in WIDTH unsigned bits; no extra width is needed.
- start while busy=1 is ignored. Operands are not re-sampled.
- y, remainder, dbz and ovf hold their values until the next FIX.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset asserted mid-operation aborts immediately: busy=0, done=0, results cleared, no done pulse. The first start after rst deasserts is accepted normally.
- start high at edge k (IDLE):
  - busy=1 after edge k.
  - CALC occupies edges k+1 … k+WIDTH.
  - FIX at edge k+WIDTH+1 writes y, remainder and the flags; done=1 and busy=0 after that edge.
  - done falls at edge k+WIDTH+2.
- Total latency is WIDTH+1 cycles from acceptance to done: 17 for WIDTH=16.
- Back-to-back: start high during the done cycle is accepted at edge k+WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=16, unsigned 100/7 -> y=14, remainder=2, done exactly 17 cycles after the start edge, busy high for 17 cycles.
- Unsigned 0xFFFF/0x8001 -> y=1, remainder=0x7FFE. This checks the WIDTH+1 partial remainder. Then 0xFFFF/0x0001 -> y=0xFFFF, remainder=0.
- Signed -7/2 (0xFFF9/0x0002) -> y=0xFFFD, remainder=0xFFFF. Then 7/-2 -> y=0xFFFD, remainder=0x0001.
- 0x1234/0 (both modes) -> y=0xFFFF, remainder=0x1234, dbz=1, same latency. Signed 0x8000/0xFFFF -> y=0x8000, remainder=0, ovf=1.
- start pulsed at cycle 5 of a running operation -> ignored, first result unchanged. start held during the done cycle -> second operation accepted, done again 17 cycles later.
- rst low at cycle 8 of CALC -> all outputs 0 immediately, no done. After release, 50/5 -> y=10, remainder=0.
